// File: rtl/onchip_mem_dp.sv
// onchip_mem_dp -- true-dual-port on-chip RAM with two Avalon-MM pipelined
// slave ports (s1, s2) on a single clock.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8, 8..128)
//   ADDR_WIDTH   word address width, depth = 2**ADDR_WIDTH
//   READ_LATENCY cycles from read acceptance to readdatavalid (1 or 2)
//   INIT_FILE    memory init file for the device configuration image
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   clken, reset_req    effective enable ce = clken & ~reset_req; ce low
//                       freezes memory, read pipelines and readdatavalid
//   sN_address          word address
//   sN_chipselect       port select
//   sN_read, sN_write   requests; read and write together is a write only
//   sN_byteenable       byte-lane write enables
//   sN_writedata        write data
//   sN_readdata         read data, holds its last value between beats
//   sN_readdatavalid    qualifies sN_readdata, one pulse per accepted read
//
// Same-address read-during-write (any port combination) returns old data.
// Write collision: per byte, s1 wins where both ports enable the lane.
module onchip_mem_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  // Only 1 and 2 are meaningful; anything else falls back to 1.
  localparam int unsigned LAT    = (READ_LATENCY == 2) ? 2 : 1;

  logic                  ce;
  logic [1:0]            wr_en;
  logic [1:0]            rd_en;
  logic [ADDR_WIDTH-1:0] addr [2];

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-port read pipeline: stage LAT-1 drives the outputs.
  logic [LAT-1:0]        pipe_valid [2];
  logic [DATA_WIDTH-1:0] pipe_data  [2][LAT];

  // Preloading is done by the configuration image through the
  // ram_init_file attribute; nothing is loaded at run time, and reset
  // never touches the array.
  if (INIT_FILE != "") begin : g_init_file
  end

  always_comb begin
    ce       = clken & ~reset_req;
    wr_en[0] = ce & s1_chipselect & s1_write;
    wr_en[1] = ce & s2_chipselect & s2_write;
    // A combined read+write is a write only, so it never enters the pipeline.
    rd_en[0] = ce & s1_chipselect & s1_read & ~s1_write;
    rd_en[1] = ce & s2_chipselect & s2_read & ~s2_write;
    addr[0]  = s1_address;
    addr[1]  = s2_address;
  end

  // s1 lanes are assigned after s2 lanes, so on a same-address collision
  // the later non-blocking update gives s1 the bytes both ports enable,
  // while bytes enabled by only one port keep that port's data.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (wr_en[1] && s2_byteenable[b])
        mem[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
      if (wr_en[0] && s1_byteenable[b])
        mem[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
    end
  end

  // Stage data only loads when a valid beat arrives, which keeps readdata
  // at its last returned value between beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        pipe_valid[p] <= '0;
        for (int unsigned s = 0; s < LAT; s++) begin
          pipe_data[p][s] <= '0;
        end
      end
    end else if (ce) begin
      for (int unsigned p = 0; p < 2; p++) begin
        pipe_valid[p][0] <= rd_en[p];
        if (rd_en[p]) begin
          pipe_data[p][0] <= mem[addr[p]];
        end
        for (int unsigned s = 1; s < LAT; s++) begin
          pipe_valid[p][s] <= pipe_valid[p][s-1];
          if (pipe_valid[p][s-1]) begin
            pipe_data[p][s] <= pipe_data[p][s-1];
          end
        end
      end
    end
  end

  // Gating with ce keeps a held beat from being presented more than once.
  always_comb begin
    s1_readdata      = pipe_data[0][LAT-1];
    s2_readdata      = pipe_data[1][LAT-1];
    s1_readdatavalid = pipe_valid[0][LAT-1] & ce;
    s2_readdatavalid = pipe_valid[1][LAT-1] & ce;
  end

endmodule

// File: tb/tb_onchip_mem_dp.sv
// Testbench for onchip_mem_dp: two instances (READ_LATENCY 1 and 2) share
// one stimulus stream; each table row is one clock cycle of inputs plus the
// expected readdatavalid/readdata of both ports of both instances.
module tb_onchip_mem_dp;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int BW = DW / 8;

  localparam logic [2:0] OP_I  = 3'b000; // selected, idle
  localparam logic [2:0] OP_R  = 3'b001; // read
  localparam logic [2:0] OP_W  = 3'b010; // write
  localparam logic [2:0] OP_RW = 3'b011; // read and write together
  localparam logic [2:0] OP_NC = 3'b101; // read with chipselect low

  // Expected index k: 0 = L1 s1, 1 = L1 s2, 2 = L2 s1, 3 = L2 s2
  typedef struct {
    logic           clken;
    logic           rr;
    logic [2:0]     op1;
    logic [AW-1:0]  a1;
    logic [BW-1:0]  be1;
    logic [DW-1:0]  d1;
    logic [2:0]     op2;
    logic [AW-1:0]  a2;
    logic [BW-1:0]  be2;
    logic [DW-1:0]  d2;
    logic [3:0]     ev;
    logic [3:0][DW-1:0] ed;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] l1_s1_rd, l1_s2_rd, l2_s1_rd, l2_s2_rd;
  logic          l1_s1_v, l1_s2_v, l2_s1_v, l2_s2_v;

  logic [3:0]         vld;
  logic [3:0][DW-1:0] rdd;
  assign vld = {l2_s2_v, l2_s1_v, l1_s2_v, l1_s1_v};
  assign rdd = {l2_s2_rd, l2_s1_rd, l1_s2_rd, l1_s1_rd};

  onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(l1_s1_rd), .s1_readdatavalid(l1_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(l1_s2_rd), .s2_readdatavalid(l1_s2_v)
  );

  onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(l2_s1_rd), .s1_readdatavalid(l2_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(l2_s2_rd), .s2_readdatavalid(l2_s2_v)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ck, input logic rr,
                     input logic [2:0] op1, input int a1, input logic [BW-1:0] be1,
                     input logic [DW-1:0] d1,
                     input logic [2:0] op2, input int a2, input logic [BW-1:0] be2,
                     input logic [DW-1:0] d2,
                     input logic [3:0] ev,
                     input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                     input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    vec_t v;
    v.clken = ck;  v.rr = rr;
    v.op1 = op1;   v.a1 = AW'(a1); v.be1 = be1; v.d1 = d1;
    v.op2 = op2;   v.a2 = AW'(a2); v.be2 = be2; v.d2 = d2;
    v.ev = ev;
    v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    clken         = v.clken;
    reset_req     = v.rr;
    s1_chipselect = ~v.op1[2];
    s1_read       = v.op1[0];
    s1_write      = v.op1[1];
    s1_address    = v.a1;
    s1_byteenable = v.be1;
    s1_writedata  = v.d1;
    s2_chipselect = ~v.op2[2];
    s2_read       = v.op2[0];
    s2_write      = v.op2[1];
    s2_address    = v.a2;
    s2_byteenable = v.be2;
    s2_writedata  = v.d2;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s valid%0d", tag, k), {{(DW-1){1'b0}}, vld[k]},
          {{(DW-1){1'b0}}, v.ev[k]});
      if (v.ev[k]) chk($sformatf("%s data%0d", tag, k), rdd[k], v.ed[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s valid%0d", tag, k), {{(DW-1){1'b0}}, vld[k]}, '0);
      chk($sformatf("%s data%0d", tag, k), rdd[k], '0);
    end
  endtask

  initial begin
    vec_t idle;
    idle = '{clken: 1'b1, rr: 1'b0, op1: OP_I, a1: '0, be1: '0, d1: '0,
             op2: OP_I, a2: '0, be2: '0, d2: '0, ev: '0, ed: '0};
    reset = 1'b1;
    drive(idle);

    // basic write/read and byte lanes
    add(1,0, OP_W,5,4'hF,32'hDEADBEEF, OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_R,5,0,0,               OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_W,7,4'hF,32'h11223344, OP_I,0,0,0, 4'b0001, 32'hDEADBEEF,0,0,0);
    add(1,0, OP_W,7,4'b0101,32'hAABBCCDD, OP_I,0,0,0, 4'b0100, 0,0,32'hDEADBEEF,0);
    add(1,0, OP_R,7,0,0,               OP_I,0,0,0, 4'b0000, 0,0,0,0);
    // write collision at address 3
    add(1,0, OP_W,3,4'b0011,32'h000000FF, OP_W,3,4'hF,32'hABCD1234,
        4'b0001, 32'h11BB33DD,0,0,0);
    add(1,0, OP_R,3,0,0, OP_R,3,0,0, 4'b0100, 0,0,32'h11BB33DD,0);
    // cross-port read-during-write at address 9
    add(1,0, OP_W,9,4'hF,32'h1, OP_I,0,0,0, 4'b0011, 32'hABCD00FF,32'hABCD00FF,0,0);
    add(1,0, OP_W,9,4'hF,32'h2, OP_R,9,0,0, 4'b1100, 0,0,32'hABCD00FF,32'hABCD00FF);
    add(1,0, OP_I,0,0,0, OP_R,9,0,0, 4'b0010, 0,32'h1,0,0);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b1010, 0,32'h2,0,32'h1);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b1000, 0,0,0,32'h2);
    // read+write is a write only; chipselect low is ignored
    add(1,0, OP_RW,5,4'hF,32'h12345678, OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_R,5,0,0,  OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_I,0,0,0,  OP_I,0,0,0, 4'b0001, 32'h12345678,0,0,0);
    add(1,0, OP_NC,5,0,0, OP_I,0,0,0, 4'b0100, 0,0,32'h12345678,0);
    add(1,0, OP_I,0,0,0,  OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_I,0,0,0,  OP_I,0,0,0, 4'b0000, 0,0,0,0);
    // 4 back-to-back reads on s2 with clken low for 3 cycles mid-stream
    add(1,0, OP_I,0,0,0, OP_R,5,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_I,0,0,0, OP_R,7,0,0, 4'b0010, 0,32'h12345678,0,0);
    add(0,0, OP_I,0,0,0, OP_R,3,0,0, 4'b0000, 0,0,0,0);
    add(0,0, OP_I,0,0,0, OP_R,3,0,0, 4'b0000, 0,0,0,0);
    add(0,0, OP_I,0,0,0, OP_R,3,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_I,0,0,0, OP_R,3,0,0, 4'b1010, 0,32'h11BB33DD,0,32'h12345678);
    add(1,0, OP_I,0,0,0, OP_R,9,0,0, 4'b1010, 0,32'hABCD00FF,0,32'h11BB33DD);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b1010, 0,32'h2,0,32'hABCD00FF);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b1000, 0,0,0,32'h2);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b0000, 0,0,0,0);
    // reset_req holds an in-flight read and blocks a write
    add(1,0, OP_R,7,0,0, OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,1, OP_W,7,4'hF,32'hFFFFFFFF, OP_I,0,0,0, 4'b0000, 0,0,0,0);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b0001, 32'h11BB33DD,0,0,0);
    add(1,0, OP_R,7,0,0, OP_I,0,0,0, 4'b0100, 0,0,32'h11BB33DD,0);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b0001, 32'h11BB33DD,0,0,0);
    add(1,0, OP_I,0,0,0, OP_I,0,0,0, 4'b0100, 0,0,32'h11BB33DD,0);

    // reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cleared("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("c%0d", i));
    end

    // reset pulse one cycle after a read is accepted
    begin
      vec_t v;
      v = idle;
      v.op1 = OP_R; v.a1 = AW'(3);
      drive(v);
      @(posedge clk);
      #1;
      drive(idle);
      reset = 1'b1;
      @(negedge clk);
      check_cleared("midflight_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // first cycle after deassertion accepts a request; no stale beats
      v = idle;
      v.op1 = OP_R; v.a1 = AW'(3);
      v.op2 = OP_R; v.a2 = AW'(5);
      run_vec(v, "post_reset0");
      v = idle;
      v.ev = 4'b0011; v.ed[0] = 32'hABCD00FF; v.ed[1] = 32'h12345678;
      run_vec(v, "post_reset1");
      v = idle;
      v.ev = 4'b1100; v.ed[2] = 32'hABCD00FF; v.ed[3] = 32'h12345678;
      run_vec(v, "post_reset2");
      run_vec(idle, "post_reset3");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
